mem_bus_port: RTL and testbench
===============================

// Module: mem_bus_port
// PURPOSE
//  Receiving end of the shared 16-bit CPU bus driven by the one-hot gate mux: holds MAR and MDR.
//  Runs SRAM read/write cycles with a fixed wait-state count and returns the LC-3 ready strobe R.
//  MDR output feeds back to the gate mux MDR input; ADDR/data/strobes go to the SRAM.
// PARAMETERS
//  WIDTH        16  bus, MAR, MDR and SRAM data width
//  WAIT_STATES  2   cycles spent in ACCESS per memory operation; legal range 1..15
// PORTS
//  Clk             in   1      system clock, all state on rising edge
//  Reset           in   1      asynchronous, active-low reset
//  Bus             in   WIDTH  shared CPU bus (gate mux output)
//  LD_MAR          in   1      load MAR from Bus
//  LD_MDR          in   1      load MDR (source chosen by MIO_EN)
//  MIO_EN          in   1      memory operation request, level, held by control FSM
//  R_W             in   1      1 = write, 0 = read; sampled at start of access
//  Data_from_SRAM  in   WIDTH  SRAM read data
//  MAR             out  WIDTH  memory address register
//  MDR             out  WIDTH  memory data register
//  ADDR            out  WIDTH  SRAM address (= MAR)
//  Data_to_SRAM    out  WIDTH  SRAM write data (= MDR)
//  CE_n, OE_n, WE_n out 1      SRAM strobes, active-low
//  R               out  1      access complete, one-cycle pulse
// BEHAVIOUR
//  - Reset (async, Reset=0): MAR=0, MDR=0, state=IDLE, count=0, op=read, R=0, CE_n=OE_n=WE_n=1.
//  - States IDLE, ACCESS, DONE, HOLD. Strobes and R decoded combinationally from state/op.
//  - IDLE: MIO_EN=1 -> ACCESS; op<=R_W, count<=0. Else stay.
//  - ACCESS: CE_n=0; read: OE_n=0, WE_n=1; write: WE_n=0, OE_n=1. count++ each cycle;
//    when count==WAIT_STATES-1 and MIO_EN=1 -> DONE.
//  - DONE (1 cycle): R=1, CE_n=0, OE_n=0 on read, WE_n=1. Next -> HOLD if MIO_EN=1, else IDLE.
//  - HOLD: strobes inactive, R=0; stay until MIO_EN=0 -> IDLE. One access per MIO_EN assertion.
//  - Latency: MIO_EN first sampled high at edge N -> R high in cycle after edge N+WAIT_STATES.
//  - MIO_EN dropped in ACCESS: abort -> IDLE next edge, R never asserted, MDR unchanged.
//  - MAR: LD_MAR=1 loads Bus only when state==IDLE (incl. the edge that enters ACCESS: the
//    access then uses the new value). LD_MAR in ACCESS/DONE/HOLD ignored.
//  - MDR: LD_MDR=1 & MIO_EN=0 & state==IDLE -> MDR<=Bus.
//    LD_MDR=1 & MIO_EN=1 & state==DONE & op=read -> MDR<=Data_from_SRAM.
//    All other LD_MDR assertions ignored (write data stable during access).
//  - LD_MAR and LD_MDR in same IDLE cycle: both load the same Bus value.
//  - R_W changes after access start: no effect (op latched).
//  - Reset asserted mid-access: strobes inactive immediately (async), R=0.
//  - No arithmetic beyond count; count width $clog2(WAIT_STATES+1), never wraps.
// STRUCTURE
//  - lc3_bus_pkg: mem_state_t enum {IDLE,ACCESS,DONE,HOLD}, WORD_W=16 constant.
//  - Single module; one always_ff for MAR/MDR/state/count/op, one always_comb for
//    next-state and strobes. No sub-module.
// TESTING
//  - Reset: Reset=0 mid-ACCESS -> MAR=0, MDR=0, R=0, CE_n=OE_n=WE_n=1 same cycle.
//  - Read: Bus=16'h3000, LD_MAR; MIO_EN=1, R_W=0, LD_MDR=1, SRAM returns 16'hBEEF ->
//    OE_n=0 for 3 cycles, R=1 exactly 2 edges after start, MDR=16'hBEEF after DONE.
//  - Write: MAR=16'h0042, MDR<=Bus 16'h1234 (MIO_EN=0); MIO_EN=1, R_W=1 -> WE_n=0 for
//    2 cycles, Data_to_SRAM=16'h1234, ADDR=16'h0042, R pulse once.
//  - Hold: keep MIO_EN=1 for 10 cycles after R -> exactly one R pulse, strobes idle in HOLD.
//  - Abort: drop MIO_EN after 1 ACCESS cycle -> IDLE, no R, MDR unchanged.
//  - Ignored loads: LD_MAR with Bus=16'hFFFF and R_W toggle during ACCESS ->
//    ADDR and op unchanged; WAIT_STATES=1 run repeats read with R after 1 edge.

Source files
------------

// File: rtl/mem_bus_port_pkg.sv
// Shared types and widths for the CPU-bus memory port (MAR/MDR + SRAM sequencer).
package mem_bus_port_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HOLD   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_bus_port_if.sv
// Bus, control and SRAM signals of the memory port.
// The master side is the CPU datapath/control plus SRAM model; the slave side is the port itself.
interface mem_bus_port_if
  import mem_bus_port_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
);

  logic [WIDTH-1:0] Bus;
  logic             LD_MAR;
  logic             LD_MDR;
  logic             MIO_EN;
  logic             R_W;
  logic [WIDTH-1:0] Data_from_SRAM;

  logic [WIDTH-1:0] MAR;
  logic [WIDTH-1:0] MDR;
  logic [WIDTH-1:0] ADDR;
  logic [WIDTH-1:0] Data_to_SRAM;
  logic             CE_n;
  logic             OE_n;
  logic             WE_n;
  logic             R;

  modport master (
    output Bus, LD_MAR, LD_MDR, MIO_EN, R_W, Data_from_SRAM,
    input  MAR, MDR, ADDR, Data_to_SRAM, CE_n, OE_n, WE_n, R
  );

  modport slave (
    input  Bus, LD_MAR, LD_MDR, MIO_EN, R_W, Data_from_SRAM,
    output MAR, MDR, ADDR, Data_to_SRAM, CE_n, OE_n, WE_n, R
  );

endinterface

// File: rtl/mem_bus_port.sv
// Memory port: holds MAR/MDR loaded from the CPU bus and runs fixed-wait SRAM cycles,
// returning a one-cycle ready strobe R per MIO_EN assertion.
module mem_bus_port
  import mem_bus_port_pkg::*;
#(
  parameter int unsigned WIDTH       = WORD_W,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_bus_port_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_STATES + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;

  logic ce_n_c, oe_n_c, we_n_c, r_c;

  // State, address/data registers and latched operation
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Next-state, register loads and strobe decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ce_n_c  = 1'b1;
    oe_n_c  = 1'b1;
    we_n_c  = 1'b1;
    r_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.LD_MAR) begin
          mar_d = bus.Bus;
        end
        if (bus.LD_MDR && !bus.MIO_EN) begin
          mdr_d = bus.Bus;
        end
        if (bus.MIO_EN) begin
          state_d = ACCESS;
          op_d    = bus.R_W;
          count_d = '0;
        end
      end

      ACCESS: begin
        ce_n_c  = 1'b0;
        oe_n_c  = op_q;
        we_n_c  = ~op_q;
        count_d = count_q + CNT_W'(1);
        // Dropping MIO_EN mid-access abandons the cycle without a ready strobe
        if (!bus.MIO_EN) begin
          state_d = IDLE;
        end else if (count_q == CNT_W'(WAIT_STATES - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        r_c    = 1'b1;
        ce_n_c = 1'b0;
        oe_n_c = op_q;
        if (bus.LD_MDR && bus.MIO_EN && !op_q) begin
          mdr_d = bus.Data_from_SRAM;
        end
        state_d = bus.MIO_EN ? HOLD : IDLE;
      end

      HOLD: begin
        if (!bus.MIO_EN) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.MAR          = mar_q;
  assign bus.MDR          = mdr_q;
  assign bus.ADDR         = mar_q;
  assign bus.Data_to_SRAM = mdr_q;
  assign bus.CE_n         = ce_n_c;
  assign bus.OE_n         = oe_n_c;
  assign bus.WE_n         = we_n_c;
  assign bus.R            = r_c;

endmodule

// File: tb/tb_mem_bus_port.sv
// Directed checks of mem_bus_port: reset, read, write, hold, abort, ignored loads,
// single-wait-state variant and asynchronous reset mid-access.
module tb_mem_bus_port;
  import mem_bus_port_pkg::*;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  mem_bus_port_if #(.WIDTH(16)) bus_a ();
  mem_bus_port_if #(.WIDTH(16)) bus_b ();

  mem_bus_port #(.WIDTH(16), .WAIT_STATES(2)) u_dut_ws2 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_a)
  );

  mem_bus_port #(.WIDTH(16), .WAIT_STATES(1)) u_dut_ws1 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int oe_lo, we_lo, r_cnt, r_at, hold_act;

    n_tests = 0;
    n_fail  = 0;

    rst_n = 1'b0;
    bus_a.Bus = '0; bus_a.LD_MAR = 0; bus_a.LD_MDR = 0; bus_a.MIO_EN = 0; bus_a.R_W = 0;
    bus_a.Data_from_SRAM = '0;
    bus_b.Bus = '0; bus_b.LD_MAR = 0; bus_b.LD_MDR = 0; bus_b.MIO_EN = 0; bus_b.R_W = 0;
    bus_b.Data_from_SRAM = '0;

    step();
    step();
    check("rst_mar",  bus_a.MAR, 16'h0000);
    check("rst_mdr",  bus_a.MDR, 16'h0000);
    check("rst_r",    16'(bus_a.R),    16'd0);
    check("rst_ce_n", 16'(bus_a.CE_n), 16'd1);
    check("rst_oe_n", 16'(bus_a.OE_n), 16'd1);
    check("rst_we_n", 16'(bus_a.WE_n), 16'd1);
    rst_n = 1'b1;
    step();

    // ---- read with 2 wait states, then 10 cycles of held MIO_EN ----
    bus_a.Bus = 16'h3000; bus_a.LD_MAR = 1;
    step();
    check("rd_mar_load", bus_a.MAR, 16'h3000);
    bus_a.LD_MAR = 0;
    bus_a.Bus = 16'h5555;
    bus_a.MIO_EN = 1; bus_a.R_W = 0; bus_a.LD_MDR = 1; bus_a.Data_from_SRAM = 16'hBEEF;
    oe_lo = 0; r_cnt = 0; r_at = -1; hold_act = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (!bus_a.OE_n) oe_lo++;
      if (bus_a.R) begin
        r_cnt++;
        if (r_at < 0) r_at = i;
      end
      if (i == 0) check("rd_addr", bus_a.ADDR, 16'h3000);
      if (i == 2) check("rd_mdr_before_done_edge", bus_a.MDR, 16'h0000);
      if (i >= 3 && (!bus_a.CE_n || !bus_a.OE_n || !bus_a.WE_n)) hold_act++;
    end
    check("rd_oe_cycles", 16'(oe_lo), 16'd3);
    check("rd_r_edge",    16'(r_at),  16'd2);
    check("hold_r_pulses", 16'(r_cnt), 16'd1);
    check("hold_strobes",  16'(hold_act), 16'd0);
    check("rd_mdr", bus_a.MDR, 16'hBEEF);
    bus_a.MIO_EN = 0; bus_a.LD_MDR = 0;
    step();
    check("rd_idle_ce_n", 16'(bus_a.CE_n), 16'd1);

    // ---- write ----
    bus_a.Bus = 16'h0042; bus_a.LD_MAR = 1;
    step();
    bus_a.LD_MAR = 0;
    bus_a.Bus = 16'h1234; bus_a.LD_MDR = 1;
    step();
    check("wr_mdr_load", bus_a.MDR, 16'h1234);
    bus_a.Bus = 16'h0000;
    bus_a.MIO_EN = 1; bus_a.R_W = 1; bus_a.Data_from_SRAM = 16'hDEAD;
    we_lo = 0; oe_lo = 0; r_cnt = 0; r_at = -1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!bus_a.WE_n) we_lo++;
      if (!bus_a.OE_n) oe_lo++;
      if (bus_a.R) begin
        r_cnt++;
        if (r_at < 0) r_at = i;
      end
      if (i == 0) begin
        check("wr_addr", bus_a.ADDR, 16'h0042);
        check("wr_data", bus_a.Data_to_SRAM, 16'h1234);
      end
    end
    check("wr_we_cycles", 16'(we_lo), 16'd2);
    check("wr_oe_cycles", 16'(oe_lo), 16'd0);
    check("wr_r_pulses",  16'(r_cnt), 16'd1);
    check("wr_r_edge",    16'(r_at),  16'd2);
    check("wr_mdr_kept",  bus_a.MDR, 16'h1234);
    bus_a.MIO_EN = 0; bus_a.LD_MDR = 0; bus_a.R_W = 0;
    step();

    // ---- abort after one ACCESS cycle ----
    bus_a.MIO_EN = 1; bus_a.R_W = 0; bus_a.LD_MDR = 1; bus_a.Data_from_SRAM = 16'hAAAA;
    step();
    check("ab_access_ce_n", 16'(bus_a.CE_n), 16'd0);
    bus_a.MIO_EN = 0; bus_a.LD_MDR = 0;
    r_cnt = 0;
    step();
    check("ab_idle_ce_n", 16'(bus_a.CE_n), 16'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus_a.R) r_cnt++;
      step();
    end
    check("ab_no_r",  16'(r_cnt), 16'd0);
    check("ab_mdr",   bus_a.MDR, 16'h1234);

    // ---- LD_MAR and R_W changes during ACCESS are ignored ----
    bus_a.MIO_EN = 1; bus_a.R_W = 0;
    step();
    bus_a.Bus = 16'hFFFF; bus_a.LD_MAR = 1; bus_a.R_W = 1;
    step();
    check("ign_addr", bus_a.ADDR, 16'h0042);
    check("ign_oe_n", 16'(bus_a.OE_n), 16'd0);
    check("ign_we_n", 16'(bus_a.WE_n), 16'd1);
    step();
    check("ign_done_r", 16'(bus_a.R), 16'd1);
    bus_a.LD_MAR = 0; bus_a.MIO_EN = 0; bus_a.R_W = 0;
    step();
    check("ign_mar", bus_a.MAR, 16'h0042);

    // ---- LD_MAR + LD_MDR in the same IDLE cycle ----
    bus_a.Bus = 16'h7777; bus_a.LD_MAR = 1; bus_a.LD_MDR = 1;
    step();
    check("both_mar", bus_a.MAR, 16'h7777);
    check("both_mdr", bus_a.MDR, 16'h7777);
    bus_a.LD_MDR = 0;

    // ---- LD_MAR on the edge entering ACCESS takes effect ----
    bus_a.Bus = 16'h0100; bus_a.LD_MAR = 1; bus_a.MIO_EN = 1;
    step();
    check("enter_addr", bus_a.ADDR, 16'h0100);
    bus_a.LD_MAR = 0; bus_a.MIO_EN = 0;
    step();
    step();

    // ---- single wait state instance ----
    bus_b.Bus = 16'h3000; bus_b.LD_MAR = 1;
    step();
    bus_b.LD_MAR = 0;
    bus_b.MIO_EN = 1; bus_b.R_W = 0; bus_b.LD_MDR = 1; bus_b.Data_from_SRAM = 16'hBEEF;
    oe_lo = 0; r_cnt = 0; r_at = -1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!bus_b.OE_n) oe_lo++;
      if (bus_b.R) begin
        r_cnt++;
        if (r_at < 0) r_at = i;
      end
    end
    check("ws1_oe_cycles", 16'(oe_lo), 16'd2);
    check("ws1_r_edge",    16'(r_at),  16'd1);
    check("ws1_r_pulses",  16'(r_cnt), 16'd1);
    check("ws1_mdr",       bus_b.MDR, 16'hBEEF);
    check("ws1_addr",      bus_b.ADDR, 16'h3000);
    bus_b.MIO_EN = 0; bus_b.LD_MDR = 0;
    step();

    // ---- async reset in the middle of an access ----
    bus_a.MIO_EN = 1; bus_a.R_W = 1;
    step();
    check("mid_ce_n_pre", 16'(bus_a.CE_n), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_mar",  bus_a.MAR, 16'h0000);
    check("mid_mdr",  bus_a.MDR, 16'h0000);
    check("mid_r",    16'(bus_a.R),    16'd0);
    check("mid_ce_n", 16'(bus_a.CE_n), 16'd1);
    check("mid_oe_n", 16'(bus_a.OE_n), 16'd1);
    check("mid_we_n", 16'(bus_a.WE_n), 16'd1);
    bus_a.MIO_EN = 0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
